// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard control with memory-wait freeze, timeout abort and saturating event counters.
module stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             mem_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state;
  logic [TW-1:0] tcnt;
  logic freeze, flush, hold, abort;
  always_comb begin
    freeze     = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    flush      = !freeze && branch_taken;
    hold       = !freeze && !branch_taken && stall;
    abort      = (state == MEM_WAIT) && !mem_ready && (tcnt == TW'(TIMEOUT - 1));
    pc_write   = !rst && !freeze && !hold;
    ifid_write = !rst && !freeze && !hold;
    pipe_write = !rst && !freeze;
    ifid_flush = rst || flush;
    idex_flush = rst || flush || hold;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      tcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (freeze) wait_cnt <= wait_cnt + CNT_W'(wait_cnt != '1);
      if (flush) flush_cnt <= flush_cnt + CNT_W'(flush_cnt != '1);
      if (hold) stall_cnt <= stall_cnt + CNT_W'(stall_cnt != '1);
      if (!freeze) state <= RUN;
      else if (state == RUN) begin
        state <= MEM_WAIT;
        tcnt  <= '0;
      end else if (abort) begin
        state   <= RUN;
        mem_err <= 1'b1;
      end else tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and random stimulus checked every cycle against a freeze-run-length reference model.
module tb_stall_ctrl;
  localparam int CNT_W = 4;
  localparam int TIMEOUT = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 0, rst, stall, branch_taken, mem_req, mem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_write, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [4:0] ctl;
  int checks = 0, errors = 0;
  int m_stall, m_flush, m_wait, m_frz;
  bit m_in_wait, m_err, known = 0;

  stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_write(pipe_write), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wait_cnt(wait_cnt), .mem_err(mem_err)
  );

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_write};
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  function automatic int sat(input int v);
    return (v + 1 > MAXC) ? MAXC : v + 1;
  endfunction

  // Reference: a freeze lasts until mem_ready, or aborts after TIMEOUT+1 consecutive frozen cycles.
  always @(negedge clk) begin
    bit frz;
    logic [4:0] e;
    frz = m_in_wait ? !mem_ready : (mem_req && !mem_ready);
    e = rst ? 5'b00110 : frz ? 5'b00000 : branch_taken ? 5'b11111 : stall ? 5'b00011 : 5'b11001;
    chk("model_ctl", ctl, e);
    if (known) begin
      chk("model_stall_cnt", stall_cnt, m_stall);
      chk("model_flush_cnt", flush_cnt, m_flush);
      chk("model_wait_cnt", wait_cnt, m_wait);
      chk("model_mem_err", mem_err, m_err);
    end
    if (rst) begin
      known = 1; m_stall = 0; m_flush = 0; m_wait = 0; m_err = 0; m_in_wait = 0; m_frz = 0;
    end else if (frz) begin
      m_wait = sat(m_wait);
      m_frz++;
      if (m_frz == TIMEOUT + 1) begin
        m_err = 1; m_in_wait = 0; m_frz = 0;
      end else m_in_wait = 1;
    end else begin
      m_in_wait = 0; m_frz = 0;
      if (branch_taken) m_flush = sat(m_flush);
      else if (stall) m_stall = sat(m_stall);
    end
  end

  task automatic cyc(input logic r, s, b, q, y, input string n, input logic [4:0] e);
    rst = r; stall = s; branch_taken = b; mem_req = q; mem_ready = y;
    #1 chk(n, ctl, e);
    @(posedge clk);
    #1;
  endtask

  task automatic cnts(input string n, input int s, f, w, input logic er);
    chk({n, "_stall_cnt"}, stall_cnt, s);
    chk({n, "_flush_cnt"}, flush_cnt, f);
    chk({n, "_wait_cnt"}, wait_cnt, w);
    chk({n, "_mem_err"}, mem_err, er);
  endtask

  initial begin
    cyc(1, 1, 1, 1, 0, "rst_ctl", 5'b00110);
    cyc(1, 0, 0, 1, 0, "rst_ctl2", 5'b00110);
    cnts("after_rst", 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, "loaduse", 5'b00011);
    cnts("loaduse", 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, "br_stall", 5'b11111);
    cnts("br_stall", 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, "freeze3", 5'b00000);
    cyc(0, 0, 0, 1, 1, "release", 5'b11001);
    cnts("release", 1, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, "run_after_release", 5'b11001);
    repeat (4) cyc(0, 0, 0, 1, 0, "timeout_freeze", 5'b00000);
    chk("mem_err_before_abort", mem_err, 0);
    cyc(0, 0, 0, 1, 0, "timeout_last", 5'b00000);
    cnts("abort", 1, 1, 8, 1);
    cyc(0, 0, 0, 0, 0, "run_after_abort", 5'b11001);
    cyc(0, 0, 0, 1, 0, "freeze_a", 5'b00000);
    cyc(0, 1, 1, 1, 1, "release_branch", 5'b11111);
    cyc(0, 0, 0, 1, 0, "freeze_b", 5'b00000);
    cyc(0, 1, 0, 1, 1, "release_stall", 5'b00011);
    cnts("releases", 2, 2, 10, 1);
    repeat (20) cyc(0, 1, 0, 0, 0, "stall20", 5'b00011);
    chk("stall_saturated", stall_cnt, 15);
    cyc(0, 0, 0, 1, 0, "freeze_c", 5'b00000);
    cyc(0, 0, 0, 1, 0, "freeze_d", 5'b00000);
    cyc(1, 0, 0, 1, 0, "rst_in_wait", 5'b00110);
    cnts("rst_in_wait", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, "run_after_rst", 5'b11001);
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 80) == 0);
      stall = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_req = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      #1;
    end
    rst = 0; stall = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
